resp_capture_serializer: RTL and testbench
==========================================

// Module: resp_capture_serializer
// PURPOSE
//  Response-side counterpart of the stimulus driver: samples the wide DUT result bus y, buffers
//  captured words, and streams each word out as a byte stream (valid/ready) for the host link.
//  Also folds every accepted word into a 32-bit MISR signature, so golden runs compare in one word.
//  Sits between the fuzzed DUT top and the result-export / comparison logic.
// PARAMETERS
//  Y_W        245            width of captured result word y
//  DEPTH      4              capture FIFO depth in words (power of 2, >=2)
//  POLY       32'h04C11DB7   MISR feedback polynomial
//  SIG_SEED   32'hFFFFFFFF   MISR value after reset
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst        in   1        synchronous reset, active-high
//  y_valid    in   1        capture strobe: sample y this cycle
//  y          in   Y_W      DUT result word
//  out_data   out  8        serialized byte, LSB-first byte order
//  out_valid  out  1        out_data valid
//  out_ready  in   1        consumer accepts byte when out_valid&&out_ready
//  out_last   out  1        marks final byte of a word
//  sig        out  32       running MISR signature
//  drop_cnt   out  16       words lost to full FIFO, saturating at 16'hFFFF
//  busy       out  1        FIFO non-empty or serializer active
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO empty, state IDLE, out_valid=0, out_last=0, out_data=0,
//   sig=SIG_SEED, drop_cnt=0, busy=0. Reset mid-word discards the word; no partial completion.
//  Capture: y_valid=1 and FIFO not full -> y written, visible next cycle. FIFO full -> word
//   dropped, drop_cnt+1 (saturating), sig NOT updated. Full = DEPTH entries held, with the
//   serializer's word holding register counted separately (total capacity DEPTH+1).
//  Simultaneous capture and pop on a full FIFO: pop frees the slot that same cycle; capture accepted.
//  MISR, per accepted word only: ypad = y zero-extended to NB*8 bits, NB = ceil(Y_W/8) (31);
//   fold = XOR of ypad[32k+:32], k = 0..ceil(NB*8/32)-1, upper chunk zero-padded;
//   sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
//  Serializer FSM:
//   IDLE: FIFO non-empty -> pop into holding reg, byte_idx=0, go SEND (out_valid rises next cycle).
//   SEND: out_data = hold[8*byte_idx+:8] (pad bits above Y_W read 0); out_last = (byte_idx==NB-1).
//         Handshake: byte_idx++; on last byte: if FIFO non-empty pop next word and stay SEND
//         (no idle bubble), else go IDLE with out_valid=0.
//   Stall: out_valid=1 && out_ready=0 -> out_data/out_last/out_valid held stable; out_valid
//   never drops once raised until handshake.
//  Latency: y accepted at cycle N with serializer idle -> first byte valid at cycle N+2.
//  busy = (FIFO count != 0) || (state == SEND).
// TESTING
//  T1 seed 0 (SIG_SEED override), y=1, out_ready=1 -> bytes 01 then 30x 00; out_last only on
//     31st byte; sig=32'h00000001.
//  T2 seed 0, y=all ones (245b) -> fold=32'hFFE00000, sig=32'hFFE00000; byte 30 = 8'h1F.
//  T3 out_ready=0, 6 back-to-back y_valid -> 5 held (1 holding + 4 FIFO), drop_cnt=1;
//     release -> 155 bytes, 5 out_last pulses, no bubbles between words.
//  T4 toggle out_ready randomly mid-word -> out_data stable while stalled; byte seq matches model.
//  T5 rst at byte 10 of a word -> next cycle out_valid=0, busy=0, sig=SIG_SEED, drop_cnt=0.
//  T6 FIFO full with pop and y_valid same cycle -> word accepted, drop_cnt unchanged.

Source files
------------

// File: rtl/resp_capture_serializer.sv
// Response capture and byte serializer.
// Captures wide result words into a small FIFO, folds each accepted word
// into a 32-bit MISR signature, and streams every word out LSB byte first
// over a valid/ready byte link with a last-byte marker.
//
// state  | meaning
// IDLE   | no word in the holding register, waiting for FIFO data
// SEND   | presenting bytes of the held word on the output link
module resp_capture_serializer #(
    parameter int unsigned Y_W      = 245,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] POLY     = 32'h04C11DB7,
    parameter logic [31:0] SIG_SEED = 32'hFFFFFFFF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           y_valid_i,
    input  logic [Y_W-1:0] y_i,
    output logic [7:0]     out_data_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic           out_last_o,
    output logic [31:0]    sig_o,
    output logic [15:0]    drop_cnt_o,
    output logic           busy_o
);

    localparam int unsigned NB  = (Y_W + 7) / 8;
    localparam int unsigned PW  = NB * 8;
    localparam int unsigned NCH = (PW + 31) / 32;
    localparam int unsigned FW  = NCH * 32;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_SEND} state_e;

    state_e          state_q, state_d;
    logic [Y_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [Y_W-1:0]  hold_q;
    logic [BW-1:0]   byte_idx_q;
    logic [31:0]     sig_q, sig_d;
    logic [15:0]     drop_cnt_q;

    logic            fifo_empty, hs, is_last, pop, push;
    logic [FW-1:0]   y_ext;
    logic [31:0]     fold;
    logic [PW-1:0]   hold_pad;

    // Handshake, pop and push qualification; a pop on the last byte frees a slot for a same-cycle capture.
    always_comb begin
        fifo_empty = (count_q == '0);
        hs         = (state_q == S_SEND) && out_ready_i;
        is_last    = (byte_idx_q == LAST_IDX);
        pop        = !fifo_empty && ((state_q == S_IDLE) || (hs && is_last));
        push       = y_valid_i && ((count_q != FULL_CNT) || pop);
    end

    // MISR fold: XOR of 32-bit chunks of the zero-extended word, then shift/feedback.
    always_comb begin
        y_ext = FW'(y_i);
        fold  = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            fold = fold ^ y_ext[32*k +: 32];
        end
        sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= y_i;
        end
    end

    // FIFO pointers, holding register, byte index, signature and drop counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            byte_idx_q <= '0;
            sig_q      <= SIG_SEED;
            drop_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
            if (pop) begin
                hold_q     <= mem_q[rd_ptr_q];
                byte_idx_q <= '0;
            end else if (hs) begin
                byte_idx_q <= byte_idx_q + BW'(1);
            end
            if (push) begin
                sig_q <= sig_d;
            end else if (y_valid_i && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Serializer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer next state; a waiting word is popped on the last byte so there is no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!fifo_empty) state_d = S_SEND;
            S_SEND: if (hs && is_last && fifo_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; everything derives from registered state so it holds steady under stall.
    always_comb begin
        hold_pad    = PW'(hold_q);
        out_valid_o = (state_q == S_SEND);
        out_last_o  = (state_q == S_SEND) && is_last;
        out_data_o  = (state_q == S_SEND) ? hold_pad[{byte_idx_q, 3'b000} +: 8] : 8'h00;
        sig_o       = sig_q;
        drop_cnt_o  = drop_cnt_q;
        busy_o      = !fifo_empty || (state_q == S_SEND);
    end

endmodule

// File: tb/tb_resp_capture_serializer.sv
// Directed bench for resp_capture_serializer (signature seed overridden to 0).
module tb_resp_capture_serializer;

    localparam int Y_W = 245;
    localparam int NB  = 31;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef logic [Y_W-1:0] y_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        y_valid = 1'b0;
    y_t          y = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [31:0] sig;
    logic [15:0] drop_cnt;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    y_t exp_q[$];
    logic [31:0] sig_m;

    resp_capture_serializer #(
        .Y_W(Y_W), .DEPTH(4), .POLY(POLY), .SIG_SEED(32'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .y_valid_i(y_valid), .y_i(y),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last), .sig_o(sig), .drop_cnt_o(drop_cnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic y_t mkword(input int k);
        logic [NB*8-1:0] t;
        for (int j = 0; j < NB; j++) t[8*j +: 8] = 8'(k * 37 + j * 11 + 3);
        return t[Y_W-1:0];
    endfunction

    function automatic logic [7:0] exp_byte(input y_t w, input int p);
        logic [NB*8-1:0] t;
        t = '0;
        t[Y_W-1:0] = w;
        return t[8*p +: 8];
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input y_t w);
        logic [255:0] z;
        logic [31:0] f;
        z = '0;
        z[Y_W-1:0] = w;
        f = '0;
        for (int k = 0; k < 8; k++) f = f ^ z[32*k +: 32];
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; y_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        sig_m = 32'h0;
    endtask

    task automatic check_idle(input string name);
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s idle: out_valid=%b busy=%b, required 0/0", name, out_valid, busy);
        end
    endtask

    // Consumes nwords from exp_q, checking bytes, last markers, stall stability and bubbles.
    task automatic drain(input int nwords, input bit rnd, input bit no_bubble, input string name);
        int pos = 0;
        int done = 0;
        bit started = 0;
        bit stalled = 0;
        bit rdy;
        logic [7:0] pdata;
        logic plast;
        for (int cyc = 0; cyc < 4000 && done < nwords; cyc++) begin
            if (stalled) begin
                vec_cnt++;
                if (out_valid !== 1'b1 || out_data !== pdata || out_last !== plast) begin
                    err_cnt++;
                    $display("FAIL %s stall: v=%b d=%h l=%b, required 1/%h/%b", name, out_valid, out_data, out_last, pdata, plast);
                end
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++; err_cnt++;
                    $display("FAIL %s extra byte %h with no word expected", name, out_data);
                    break;
                end
                vec_cnt++;
                if (out_data !== exp_byte(exp_q[0], pos)) begin
                    err_cnt++;
                    $display("FAIL %s byte w%0d b%0d: got %h, required %h", name, done, pos, out_data, exp_byte(exp_q[0], pos));
                end
                vec_cnt++;
                if (out_last !== (pos == NB - 1)) begin
                    err_cnt++;
                    $display("FAIL %s last w%0d b%0d: got %b, required %b", name, done, pos, out_last, (pos == NB - 1));
                end
                started = 1;
            end else if (no_bubble && started) begin
                vec_cnt++; err_cnt++;
                $display("FAIL %s bubble at w%0d b%0d: out_valid 0, required 1", name, done, pos);
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            stalled = (out_valid === 1'b1) && !rdy;
            pdata = out_data;
            plast = out_last;
            if (out_valid === 1'b1 && rdy) begin
                pos++;
                if (pos == NB) begin
                    pos = 0;
                    void'(exp_q.pop_front());
                    done++;
                end
            end
            tick();
        end
        vec_cnt++;
        if (done != nwords) begin
            err_cnt++;
            $display("FAIL %s word count: got %0d, required %0d", name, done, nwords);
        end
    endtask

    // Six captures with the link stalled: five held, one dropped.
    task automatic fill6(input int base, input string name);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            y_valid = 1'b1;
            y = mkword(base + i);
            if (i < 5) begin
                exp_q.push_back(y);
                sig_m = misr_step(sig_m, y);
            end
            tick();
        end
        y_valid = 1'b0;
        vec_cnt++;
        if (drop_cnt !== 16'd1) begin
            err_cnt++;
            $display("FAIL %s drop_cnt: got %0d, required 1", name, drop_cnt);
        end
        vec_cnt++;
        if (sig !== sig_m) begin
            err_cnt++;
            $display("FAIL %s sig: got %h, required %h", name, sig, sig_m);
        end
        vec_cnt++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s held: out_valid=%b busy=%b, required 1/1", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset outputs: v=%b l=%b d=%h, required 0/0/00", out_valid, out_last, out_data);
        end
        vec_cnt++;
        if (sig !== 32'h0 || drop_cnt !== 16'h0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset state: sig=%h drop=%h busy=%b, required 0/0/0", sig, drop_cnt, busy);
        end
    endtask

    task automatic test_single(input y_t w, input logic [31:0] exp_sig, input string name);
        do_reset();
        out_ready = 1'b1;
        y_valid = 1'b1;
        y = w;
        exp_q.push_back(w);
        tick();
        y_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s latency N+1: v=%b busy=%b, required 0/1", name, out_valid, busy);
        end
        vec_cnt++;
        if (sig !== exp_sig) begin
            err_cnt++;
            $display("FAIL %s sig: got %h, required %h", name, sig, exp_sig);
        end
        tick();
        vec_cnt++;
        if (out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s latency N+2: out_valid=%b, required 1", name, out_valid);
        end
        drain(1, 0, 1, name);
        check_idle(name);
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill6(0, "b2b");
        vec_cnt++;
        if (out_data !== exp_byte(mkword(0), 0)) begin
            err_cnt++;
            $display("FAIL b2b held byte: got %h, required %h", out_data, exp_byte(mkword(0), 0));
        end
        drain(5, 0, 1, "b2b");
        check_idle("b2b");
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            y_valid = 1'b1;
            y = mkword(20 + i);
            exp_q.push_back(y);
            sig_m = misr_step(sig_m, y);
            tick();
        end
        y_valid = 1'b0;
        drain(2, 1, 0, "stall");
        out_ready = 1'b0;
        tick();
        check_idle("stall");
        vec_cnt++;
        if (sig !== sig_m) begin
            err_cnt++;
            $display("FAIL stall sig: got %h, required %h", sig, sig_m);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        fill6(40, "rstmid");
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        vec_cnt++;
        if (out_data !== exp_byte(mkword(40), 10)) begin
            err_cnt++;
            $display("FAIL rstmid byte10: got %h, required %h", out_data, exp_byte(mkword(40), 10));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sig !== 32'h0 || drop_cnt !== 16'h0) begin
            err_cnt++;
            $display("FAIL rstmid after: v=%b busy=%b sig=%h drop=%h, required 0/0/0/0", out_valid, busy, sig, drop_cnt);
        end
        exp_q.delete();
        sig_m = 32'h0;
        tick();
        check_idle("rstmid hold");
    endtask

    task automatic test_full_pop_push();
        y_t w6;
        do_reset();
        fill6(60, "fullpp");
        out_ready = 1'b1;
        for (int i = 0; i < NB - 1; i++) tick();
        vec_cnt++;
        if (out_last !== 1'b1) begin
            err_cnt++;
            $display("FAIL fullpp last: got %b, required 1", out_last);
        end
        w6 = mkword(99);
        y_valid = 1'b1;
        y = w6;
        exp_q.push_back(w6);
        sig_m = misr_step(sig_m, w6);
        void'(exp_q.pop_front());
        tick();
        y_valid = 1'b0;
        vec_cnt++;
        if (drop_cnt !== 16'd1 || sig !== sig_m) begin
            err_cnt++;
            $display("FAIL fullpp accept: drop=%0d sig=%h, required 1/%h", drop_cnt, sig, sig_m);
        end
        drain(5, 0, 1, "fullpp");
        check_idle("fullpp");
    endtask

    initial begin
        test_reset();
        test_single(y_t'(1), 32'h00000001, "one");
        test_single({Y_W{1'b1}}, 32'hFFE00000, "ones");
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_full_pop_push();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
